// File: rtl/serial_compare_driver.sv
// Bit-serial N-bit magnitude comparator driver for an external 1-bit K/L compare cell.
// Optional macro SERIAL_COMPARE_EARLY_EXIT_EN: finish as soon as the verdict is decided.
module serial_compare_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_word,
  input  logic [WIDTH-1:0] b_word,
  output logic             busy,
  output logic             a_bit,
  output logic             b_bit,
  output logic             k_out,
  output logic             l_out,
  input  logic             k_in,
  input  logic             l_in,
  output logic             done,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       kl_q;
  logic             finish;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    finish  = 1'b0;
    case (state_q)
      IDLE:  if (start) state_d = SHIFT;
      SHIFT: begin
`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
        // once the cell leaves "equal so far" no later bit can change the verdict
        finish = (cnt == '0) || ({k_in, l_in} != 2'b11);
`else
        finish = (cnt == '0);
`endif
        if (finish) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr <= '0;
      b_sr <= '0;
      cnt  <= '0;
      kl_q <= 2'b11;
      gt   <= 1'b0;
      lt   <= 1'b0;
      eq   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          a_sr <= a_word;
          b_sr <= b_word;
          cnt  <= CNT_W'(WIDTH - 1);
          kl_q <= 2'b11;
        end
        SHIFT: begin
          kl_q <= {k_in, l_in};
          a_sr <= {a_sr[WIDTH-2:0], 1'b0};
          b_sr <= {b_sr[WIDTH-2:0], 1'b0};
          cnt  <= cnt - CNT_W'(1);
          if (finish) begin
            gt <=  k_in & ~l_in;
            lt <= ~k_in &  l_in;
            eq <=  k_in &  l_in;
          end
        end
        DONE:    kl_q <= 2'b11;
        default: kl_q <= 2'b11;
      endcase
    end
  end

  // cell-facing outputs depend only on registers, never on k_in/l_in
  assign busy  = (state_q != IDLE);
  assign done  = (state_q == DONE);
  assign a_bit = (state_q == SHIFT) & a_sr[WIDTH-1];
  assign b_bit = (state_q == SHIFT) & b_sr[WIDTH-1];
  assign k_out = (state_q == SHIFT) ? kl_q[1] : 1'b1;
  assign l_out = (state_q == SHIFT) ? kl_q[0] : 1'b1;

endmodule

// File: tb/tb_serial_compare_driver.sv
// Directed bench for serial_compare_driver with a behavioural 1-bit compare cell.
module tb_serial_compare_driver;

`ifdef SERIAL_COMPARE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  localparam int GT = 4, LT = 2, EQ = 1;

  logic       clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] a_word = '0, b_word = '0;
  logic       busy, a_bit, b_bit, k_out, l_out, k_in, l_in, done, gt, lt, eq;
  int         n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  serial_compare_driver #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a_word(a_word), .b_word(b_word),
    .busy(busy), .a_bit(a_bit), .b_bit(b_bit), .k_out(k_out), .l_out(l_out),
    .k_in(k_in), .l_in(l_in), .done(done), .gt(gt), .lt(lt), .eq(eq)
  );

  // compare cell: keeps a decided state, otherwise resolves on the current bits
  always_comb begin
    k_in = k_out;
    l_in = l_out;
    if (k_out & l_out) begin
      k_in = a_bit | ~b_bit;
      l_in = ~a_bit | b_bit;
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int verdict();
    return {29'd0, gt, lt, eq};
  endfunction

  // start in cycle 0, expect done in cycle exp_cyc; prev_v is the verdict still held in cycle 1
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input int exp_cyc, input int exp_v, input int prev_v);
    int n;
    bit got;
    @(negedge clk); start = 1'b1; a_word = a; b_word = b;
    @(negedge clk); start = 1'b0;
    n = 1; got = 1'b0;
    chk({tag, "_hold"}, verdict(), prev_v);
    chk({tag, "_busy"}, int'(busy), 1);
    while (n < 40 && !got) begin
      if (done) got = 1'b1;
      else begin @(negedge clk); n++; end
    end
    chk({tag, "_lat"}, n, exp_cyc);
    chk({tag, "_v"}, verdict(), exp_v);
    @(negedge clk);
    chk({tag, "_pulse"}, int'(done), 0);
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin
    int dcnt, d1, d2, v1, v2;
    logic [7:0] pat;

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_v", verdict(), 0);
    chk("rst_kl", int'({k_out, l_out}), 3);
    chk("rst_ab", int'({a_bit, b_bit}), 0);
    reset = 1'b0;

    run_cmp("a5_5a", 8'hA5, 8'h5A, EE ? 2 : 9, GT, 0);

    // equal operands: watch the streamed bits and the K/L state
    pat = 8'h3C;
    @(negedge clk); start = 1'b1; a_word = pat; b_word = pat;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); start = 1'b0;
      chk($sformatf("3c_abit%0d", i + 1), int'(a_bit), int'(pat[7 - i]));
      chk($sformatf("3c_kl%0d", i + 1), int'({k_out, l_out}), 3);
    end
    @(negedge clk);
    chk("3c_done9", int'(done), 1);
    chk("3c_v", verdict(), EQ);
    chk("3c_kl_done", int'({k_out, l_out}), 3);
    @(negedge clk);

    run_cmp("10_11", 8'h10, 8'h11, 9, LT, EQ);

    // starts while busy are ignored; start in the IDLE cycle after DONE is accepted
    dcnt = 0; d1 = 0; d2 = 0; v1 = 0; v2 = 0;
    for (int cyc = 0; cyc <= 22; cyc++) begin
      @(negedge clk);
      if (cyc > 0 && done) begin
        dcnt++;
        if (dcnt == 1) begin d1 = cyc; v1 = verdict(); end
        else begin d2 = cyc; v2 = verdict(); end
      end
      start = (cyc == 0 || cyc == 3 || cyc == 9 || cyc == 10);
      a_word = (cyc == 0) ? 8'h66 : (cyc == 10) ? 8'h01 : 8'hFF;
      b_word = (cyc == 0) ? 8'h66 : 8'h00;
    end
    start = 1'b0;
    chk("ign_count", dcnt, 2);
    chk("ign_d1", d1, 9);
    chk("ign_v1", v1, EQ);
    chk("ign_d2", d2, 19);
    chk("ign_v2", v2, GT);

    // reset in cycle 4 abandons the compare
    dcnt = 0;
    for (int cyc = 0; cyc <= 20; cyc++) begin
      @(negedge clk);
      if (cyc == 5) begin
        chk("mrst_busy", int'(busy), 0);
        chk("mrst_done", int'(done), 0);
        chk("mrst_v", verdict(), 0);
        chk("mrst_kl", int'({k_out, l_out}), 3);
      end
      if (cyc > 0 && done) dcnt++;
      start = (cyc == 0);
      a_word = 8'h55; b_word = 8'h55;
      reset = (cyc == 4);
    end
    start = 1'b0; reset = 1'b0;
    chk("mrst_nodone", dcnt, 0);
    run_cmp("post_rst", 8'h80, 8'h7F, EE ? 2 : 9, GT, 0);

    // back to back
    run_cmp("ff_00", 8'hFF, 8'h00, EE ? 2 : 9, GT, GT);
    run_cmp("00_ff", 8'h00, 8'hFF, EE ? 2 : 9, LT, GT);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/serial_compare_driver.md
Name: serial_compare_driver

Overview:
- Sequential driver/controller for the external combinational 1-bit magnitude-compare cell (inputs Ki, Li, A, B; outputs K0, L0).
- Accepts two WIDTH-bit words on a start strobe and streams them to the cell MSB-first, one bit pair per clock.
- Feeds the initial K/L state to the cell and registers the returned K0/L0 each cycle as the next state.
- Reports the final greater/less/equal verdict with a one-cycle done pulse.
- Turns one combinational cell into a bit-serial N-bit comparator.

Parameters:
- WIDTH, 8, operand width in bits (legal range 2 to 32).
- CNT_W, $clog2(WIDTH), width of the internal bit counter (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to compare; sampled only in IDLE.
- a_word  input  WIDTH  operand A, captured when start is accepted.
- b_word  input  WIDTH  operand B, captured when start is accepted.
- busy  output  1  high in SHIFT and DONE.
- a_bit  output  1  current A bit to the cell's A input.
- b_bit  output  1  current B bit to the cell's B input.
- k_out  output  1  state to the cell's Ki input.
- l_out  output  1  state to the cell's Li input.
- k_in  input  1  cell's K0 output.
- l_in  input  1  cell's L0 output.
- done  output  1  one-cycle pulse when the verdict is valid.
- gt  output  1  A>B.
- lt  output  1  A<B.
- eq  output  1  A==B.

Behaviour:
- Clocking: single clock domain. Reset is synchronous and active-high. The reset check has priority over every other action.
- Reset values:
  - FSM returns to IDLE.
  - busy=0, done=0, gt=0, lt=0, eq=0.
  - a_bit=0, b_bit=0.
  - K/L state register = 11, so k_out=1 and l_out=1.
  - Shift registers and counter are cleared.
- K/L encoding:
  - 11 = equal so far.
  - 10 = A greater.
  - 01 = A less.
  - 00 = illegal; the cell never produces it.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - a_bit=b_bit=0; k_out=l_out=1.
  - When start=1: capture a_word and b_word into shift registers, set the K/L register to 11, load the counter with WIDTH-1, and go to SHIFT.
  - When start=0: stay in IDLE.
- SHIFT:
  - a_bit and b_bit are the MSBs of the A and B shift registers; {k_out,l_out} = K/L register. These outputs come from registers only, with no combinational path from k_in/l_in.
  - Each clock: K/L register <= {k_in,l_in}; both shift registers shift left by 1 (zero fill); counter decrements.
  - When the counter is 0: latch gt = k_in&~l_in, lt = ~k_in&l_in, eq = k_in&l_in, then go to DONE.
- DONE:
  - done=1 for exactly one cycle; a_bit=b_bit=0; k_out=l_out=1.
  - Next state is always IDLE.
- Start handling: start is ignored while busy=1; no queuing. A start in the IDLE cycle that follows DONE is accepted.
- Latency: if start is sampled in cycle 0, SHIFT occupies cycles 1..WIDTH, done is high in cycle WIDTH+1, and busy is low again in cycle WIDTH+2. Throughput is one compare per WIDTH+2 cycles.
- Verdict outputs: gt/lt/eq hold their value from one done until the next done or reset. Exactly one is high after any legal compare. An illegal final 00 yields all three low.
- Reset mid-operation: the compare is abandoned, no done pulse is issued, and all outputs take their reset values in the next cycle.
- Operand values are arbitrary unsigned; there is no sign handling.

Optional Feature:
- Macro: SERIAL_COMPARE_EARLY_EXIT_EN.
- When defined: in SHIFT, if {k_in,l_in} != 11 the FSM latches the verdict and goes to DONE immediately, regardless of the counter, because the result can no longer change.
  - If the first differing bit is at position p counted from the MSB (p=0 is the MSB), done is high in cycle p+2.
  - Equal operands still take the full WIDTH+1 cycles.
- When undefined: SHIFT always runs the full WIDTH cycles. Verdicts are identical in both builds; only latency differs.

Test Plan (WIDTH=8, bench models the cell behaviourally; start sampled in cycle 0 unless stated):
- a_word=0xA5, b_word=0x5A.
  - Feature off: done in cycle 9 with gt=1, lt=0, eq=0.
  - Feature on: done in cycle 2 with the same verdict.
- a_word=0x3C, b_word=0x3C -> done in cycle 9 with eq=1 in both builds. Monitor shows a_bit sequence 0,0,1,1,1,1,0,0 in cycles 1-8 and k_out=l_out=1 throughout.
- a_word=0x10, b_word=0x11 (differ only at the LSB) -> done in cycle 9 with lt=1 in both builds.
- Start pulsed again in cycles 3 and 9 while busy -> ignored; exactly one done; verdict from the first operands. A start in cycle 10 (IDLE) is accepted and gives done in cycle 19.
- Reset asserted in cycle 4 of a compare -> cycle 5 shows busy=0, done=0, gt=lt=eq=0, k_out=l_out=1, and no done appears afterward. A new compare then completes normally.
- Back-to-back compares 0xFF vs 0x00, then 0x00 vs 0xFF -> gt=1 held until the second done, then lt=1. done is high for exactly one cycle each time.
